// File: rtl/tile_pkg.sv
// Shared definitions for the tile light dispatcher.
// Purpose : screen tiling constants, the mask/light-id types and the
//           dispatcher state encoding.
// Contents: TILE_W, TILE_H, NTX, NTY, MAX_LIGHTS, LW, AW_MAX
//           tile_idx_t, light_id_t, light_mask_t, disp_state_t
package tile_pkg;

  localparam int TILE_W     = 16;
  localparam int TILE_H     = 16;
  localparam int NTX        = 120;                // 1920 / 16
  localparam int NTY        = 68;                 // 1080 / 16 (rounded up)
  localparam int MAX_LIGHTS = 32;
  localparam int LW         = $clog2(MAX_LIGHTS);
  localparam int AW_MAX     = $clog2(NTX * NTY);

  // Tile index at the full-resolution screen size.
  typedef logic [AW_MAX-1:0]     tile_idx_t;
  typedef logic [LW-1:0]         light_id_t;
  typedef logic [MAX_LIGHTS-1:0] light_mask_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_EMIT,
    ST_ADV,
    ST_DONE
  } disp_state_t;

endpackage

// File: rtl/tile_light_dispatcher_if.sv
// Bus bundle for the tile light dispatcher.
// Purpose : groups the frame control, mask RAM port and work-item stream.
// Ports   : start/busy/done            frame control
//           mask_rd_en/addr/data       mask RAM read (data one cycle after en)
//           mask_clr_en                zero-write to the previously read addr
//           out_valid/out_ready        work-item handshake
//           out_tile_x/y, out_light_id, out_last, out_empty   work-item payload
// Modports: master = dispatcher side, slave = environment side.
interface tile_light_dispatcher_if #(
  parameter int NTX = tile_pkg::NTX,
  parameter int NTY = tile_pkg::NTY,
  parameter int AW  = $clog2(NTX * NTY),
  parameter int XW  = $clog2(NTX),
  parameter int YW  = $clog2(NTY)
) ();
  import tile_pkg::*;

  logic          start;
  logic          busy;
  logic          done;
  logic          mask_rd_en;
  logic [AW-1:0] mask_rd_addr;
  light_mask_t   mask_rd_data;
  logic          mask_clr_en;
  logic          out_valid;
  logic          out_ready;
  logic [XW-1:0] out_tile_x;
  logic [YW-1:0] out_tile_y;
  light_id_t     out_light_id;
  logic          out_last;
  logic          out_empty;

  modport master (
    input  start, mask_rd_data, out_ready,
    output busy, done, mask_rd_en, mask_rd_addr, mask_clr_en,
    output out_valid, out_tile_x, out_tile_y, out_light_id, out_last, out_empty
  );

  modport slave (
    output start, mask_rd_data, out_ready,
    input  busy, done, mask_rd_en, mask_rd_addr, mask_clr_en,
    input  out_valid, out_tile_x, out_tile_y, out_light_id, out_last, out_empty
  );

endinterface

// File: rtl/tile_light_dispatcher_lowest_bit_pick.sv
// lowest_bit_pick: combinational lowest-set-bit finder for a light mask.
// Ports: mask        in   light mask
//        index       out  position of the lowest set bit (0 when mask is 0)
//        any_set     out  mask has at least one set bit
//        single_bit  out  mask has exactly one set bit
module lowest_bit_pick
  import tile_pkg::*;
(
  input  light_mask_t mask,
  output light_id_t   index,
  output logic        any_set,
  output logic        single_bit
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    for (int i = MAX_LIGHTS - 1; i >= 0; i--) begin
      if (mask[i]) index = light_id_t'(i);
    end
  end

  assign any_set    = |mask;
  // Clearing the lowest set bit leaves zero only for a one-hot mask.
  assign single_bit = any_set && ((mask & (mask - light_mask_t'(1))) == '0);

endmodule

// File: rtl/tile_light_dispatcher.sv
// tile_light_dispatcher: per-frame walker over the tile light-mask RAM.
// On start it reads every tile mask in raster order, clears it behind the
// read, and emits one (tile_x, tile_y, light_id) item per set bit, lowest
// light first.
// Ports: clk    rising-edge clock
//        rst_n  synchronous active-low reset (aborts a walk, no done pulse)
//        bus    tile_light_dispatcher_if.master (frame control, mask RAM, items)
// Option: TILE_DISPATCH_EMPTY_EN -- when defined, each empty tile yields one
//         item with out_empty=1, out_last=1, out_light_id=0; otherwise empty
//         tiles are skipped and out_empty is constant 0.
module tile_light_dispatcher #(
  parameter int NTX = tile_pkg::NTX,
  parameter int NTY = tile_pkg::NTY
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tile_light_dispatcher_if.master bus
);
  import tile_pkg::*;

  localparam int NT = NTX * NTY;
  localparam int AW = $clog2(NT);
  localparam int XW = $clog2(NTX);
  localparam int YW = $clog2(NTY);

  disp_state_t   state_reg, state_next;
  logic [XW-1:0] tx_reg;
  logic [YW-1:0] ty_reg;
  logic [AW-1:0] addr_reg;
  light_mask_t   pend_reg;
  logic          done_reg;

  light_id_t     pick_idx;
  logic          pick_any;
  logic          pick_one;
  logic          empty_item;
  logic          emit_valid;
  logic          item_last;
  logic          accept;
  logic          last_tile;

`ifdef TILE_DISPATCH_EMPTY_EN
  logic          empty_reg;
  assign empty_item = empty_reg;
`else
  assign empty_item = 1'b0;
`endif

  lowest_bit_pick u_pick (
    .mask       (pend_reg),
    .index      (pick_idx),
    .any_set    (pick_any),
    .single_bit (pick_one)
  );

  assign emit_valid = (state_reg == ST_EMIT) && (pick_any || empty_item);
  assign item_last  = empty_item || pick_one;
  assign accept     = emit_valid && bus.out_ready;
  assign last_tile  = (addr_reg == AW'(NT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.start) state_next = ST_READ;
      ST_READ: state_next = ST_WAIT;
      ST_WAIT: begin
`ifdef TILE_DISPATCH_EMPTY_EN
        state_next = ST_EMIT;
`else
        state_next = (bus.mask_rd_data != '0) ? ST_EMIT : ST_ADV;
`endif
      end
      ST_EMIT: if (accept && item_last) state_next = ST_ADV;
      ST_ADV:  state_next = last_tile ? ST_DONE : ST_READ;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Tile counters, pending mask and the registered done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_reg    <= '0;
      ty_reg    <= '0;
      addr_reg  <= '0;
      pend_reg  <= '0;
      done_reg  <= 1'b0;
`ifdef TILE_DISPATCH_EMPTY_EN
      empty_reg <= 1'b0;
`endif
    end else begin
      done_reg <= (state_reg == ST_DONE);
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            tx_reg   <= '0;
            ty_reg   <= '0;
            addr_reg <= '0;
          end
        end
        ST_WAIT: begin
          pend_reg  <= bus.mask_rd_data;
`ifdef TILE_DISPATCH_EMPTY_EN
          empty_reg <= (bus.mask_rd_data == '0);
`endif
        end
        ST_EMIT: begin
          if (accept) begin
            // Drop the lowest set bit, i.e. the item just accepted.
            pend_reg  <= pend_reg & (pend_reg - light_mask_t'(1));
`ifdef TILE_DISPATCH_EMPTY_EN
            empty_reg <= 1'b0;
`endif
          end
        end
        ST_ADV: begin
          // Counters hold on the final tile so IDLE keeps a valid address.
          if (!last_tile) begin
            addr_reg <= addr_reg + AW'(1);
            if (tx_reg == XW'(NTX - 1)) begin
              tx_reg <= '0;
              ty_reg <= ty_reg + YW'(1);
            end else begin
              tx_reg <= tx_reg + XW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.busy         = (state_reg != ST_IDLE);
    bus.done         = done_reg;
    bus.mask_rd_en   = (state_reg == ST_READ);
    bus.mask_clr_en  = (state_reg == ST_WAIT);
    bus.mask_rd_addr = addr_reg;
    bus.out_valid    = emit_valid;
    bus.out_tile_x   = tx_reg;
    bus.out_tile_y   = ty_reg;
    bus.out_light_id = empty_item ? light_id_t'(0) : pick_idx;
    bus.out_last     = emit_valid && item_last;
    bus.out_empty    = empty_item;
  end

endmodule
